// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch
//
// Instruction-fetch prefetch queue. It issues sequential reads to an
// instruction memory with one cycle of read latency. Returned words are
// buffered in a DEPTH-entry FIFO together with the address they were fetched
// from. The head of the FIFO is presented downstream as {pc, instruction},
// where pc is the fetch address plus PC_STEP. A taken branch flushes the
// queue, drops any response landing in the same cycle, and restarts fetching
// at the branch target.
//
// Handshake: the head entry is transferred on any rising edge where
// out_valid=1 and out_ready=1, unless branch_taken=1 in that cycle. out_valid
// does not depend on out_ready. out_ready low acts as a freeze of the
// consumer.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   branch_taken   : redirect request (flush + new fetch address)
//   branch_address : redirect target
//   imem_req       : memory read strobe (combinational)
//   imem_addr      : memory read address (the current fetch PC)
//   imem_rdata     : read data, valid the cycle after imem_req
//   out_valid      : queue head valid
//   out_ready      : consumer accepts the head
//   pc             : head fetch address + PC_STEP (0 when empty)
//   instruction    : head instruction word (0 when empty)
// ---------------------------------------------------------------------------
module if_prefetch #(
    parameter int                    BIT_NUMBER = 32,
    parameter int                    DEPTH      = 4,
    parameter int                    PC_STEP    = 4,
    parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_address,
    output logic                  imem_req,
    output logic [BIT_NUMBER-1:0] imem_addr,
    input  logic [BIT_NUMBER-1:0] imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_NUMBER-1:0] pc,
    output logic [BIT_NUMBER-1:0] instruction
);

    localparam int                    PW   = $clog2(DEPTH);
    localparam logic [BIT_NUMBER-1:0] STEP = BIT_NUMBER'(PC_STEP);

    logic [BIT_NUMBER-1:0] r_fetch_pc;
    logic [BIT_NUMBER-1:0] r_inflight_addr;
    logic                  r_inflight;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;
    logic [BIT_NUMBER-1:0] r_addr_mem [DEPTH];
    logic [BIT_NUMBER-1:0] r_data_mem [DEPTH];

    logic [PW+1:0]         w_occupancy;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_nonempty;

    // Slots already filled plus the one response that may still be on its way.
    // Issuing only while this is below DEPTH guarantees every response a slot.
    assign w_occupancy = {1'b0, r_count} + {{(PW+1){1'b0}}, r_inflight};
    assign w_issue     = !branch_taken && (w_occupancy < (PW+2)'(DEPTH));
    assign w_nonempty  = (r_count != '0);
    assign w_push      = r_inflight && !branch_taken;
    assign w_pop       = w_nonempty && out_ready && !branch_taken;

    assign imem_req    = w_issue;
    assign imem_addr   = r_fetch_pc;

    // Control state: fetch PC, in-flight tracking, pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc      <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
        end else begin
            // Never set during a branch cycle, so the cycle after a branch
            // starts with nothing in flight and an empty queue.
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_addr <= r_fetch_pc;
            end

            if (branch_taken) begin
                r_fetch_pc <= branch_address;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + STEP;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PW+1)'(1);
                    2'b01:   r_count <= r_count - (PW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= r_inflight_addr;
            r_data_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    assign out_valid   = w_nonempty;
    assign pc          = w_nonempty ? (r_addr_mem[r_rd_ptr] + STEP) : '0;
    assign instruction = w_nonempty ? r_data_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch
//
// Bench for if_prefetch with default parameters. The memory returns
// address + 0x100 one cycle after each read. A queue-based reference model
// predicts every output on every cycle outside reset. Directed sequences
// cover streaming, back-pressure, branches, back-to-back branches, reset
// mid-stream and PC wrap, with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_if_prefetch;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] instruction;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc             (pc),
    .instruction    (instruction)
  );

  // Instruction memory: word at address a is a + 0x100, one-cycle latency.
  always @(posedge clk) imem_rdata <= imem_addr + 32'h100;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the fetch addresses of buffered instructions, oldest first.
  logic [31:0] exp_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_inflight_addr;
  bit          m_inflight;

  function automatic bit m_req();
    return !branch_taken && ((exp_q.size() + (m_inflight ? 1 : 0)) < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_fetch         = 32'h0;
      m_inflight      = 0;
      m_inflight_addr = 32'h0;
    end else begin
      bit req;
      req = m_req();
      if (branch_taken) begin
        exp_q.delete();
        m_fetch = branch_address;
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (m_inflight) exp_q.push_back(m_inflight_addr);
      end
      if (exp_q.size() > DEPTH) begin
        n_checks++;
        n_errors++;
        $display("FAIL model_overflow: got %0d entries, expected at most %0d", exp_q.size(), DEPTH);
      end
      if (req) begin
        m_inflight_addr = m_fetch;
        m_fetch         = m_fetch + 32'd4;
      end
      m_inflight = req;
    end
  end

  // Compare every cycle, mid-low-phase, outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      bit          ev;
      logic [31:0] ep;
      logic [31:0] ei;
      ev = (exp_q.size() != 0);
      ep = ev ? exp_q[0] + 32'd4   : 32'h0;
      ei = ev ? exp_q[0] + 32'h100 : 32'h0;
      check("m_imem_req",    {31'b0, imem_req},  {31'b0, m_req()});
      check("m_imem_addr",   imem_addr,          m_fetch);
      check("m_out_valid",   {31'b0, out_valid}, {31'b0, ev});
      check("m_pc",          pc,                 ep);
      check("m_instruction", instruction,        ei);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [31:0] p, input logic [31:0] i);
    check({name, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    check({name, "_pc"},    pc,                 p);
    check({name, "_instr"}, instruction,        i);
  endtask

  // Assert reset, check outputs clear immediately, release after one edge.
  task automatic do_reset(input logic rdy);
    rst       = 1'b1;
    out_ready = rdy;
    #1;
    check_out("reset", 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_reset_req",  {31'b0, imem_req}, 32'h1);
    check("post_reset_addr", imem_addr,         32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [19:0] pat;
    rst            = 1'b1;
    branch_taken   = 1'b0;
    branch_address = 32'h0;
    out_ready      = 1'b1;
    tick();

    // Streaming with out_ready high: 2-cycle latency, then one per cycle.
    do_reset(1'b1);
    tick();
    check_out("stream_c1", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("stream_c2", 1'b1, 32'h4, 32'h100);
    tick();
    check_out("stream_c3", 1'b1, 32'h8, 32'h104);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("stream_n", 1'b1, 32'hC + 32'(4 * i), 32'h108 + 32'(4 * i));
    end

    // Back-pressure from reset: fills to DEPTH, then drains with no gap.
    do_reset(1'b0);
    repeat (5) tick();
    check_out("full", 1'b1, 32'h4, 32'h100);
    check("full_req", {31'b0, imem_req}, 32'h0);
    repeat (3) tick();
    check_out("full_hold", 1'b1, 32'h4, 32'h100);
    check("full_hold_req", {31'b0, imem_req}, 32'h0);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_out("drain", 1'b1, 32'h4 + 32'(4 * i), 32'h100 + 32'(4 * i));
    end

    // Branch with 3 entries buffered and one request in flight.
    do_reset(1'b0);
    repeat (4) tick();
    check_out("pre_branch", 1'b1, 32'h4, 32'h100);
    branch_taken   = 1'b1;
    branch_address = 32'h200;
    #1;
    check("branch_req_low", {31'b0, imem_req}, 32'h0);
    tick();
    branch_taken = 1'b0;
    #1;
    check_out("after_branch", 1'b0, 32'h0, 32'h0);
    check("after_branch_addr", imem_addr,         32'h200);
    check("after_branch_req",  {31'b0, imem_req}, 32'h1);
    out_ready = 1'b1;
    tick();
    check_out("branch_lat", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("branch_first", 1'b1, 32'h204, 32'h300);
    repeat (3) tick();

    // Two consecutive branches: last target wins.
    branch_taken   = 1'b1;
    branch_address = 32'h300;
    tick();
    branch_address = 32'h400;
    #1;
    check("bb_req_low", {31'b0, imem_req}, 32'h0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("bb_addr", imem_addr,         32'h400);
    check("bb_req",  {31'b0, imem_req}, 32'h1);
    tick();
    check_out("bb_lat", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("bb_first", 1'b1, 32'h404, 32'h500);
    repeat (3) tick();

    // Reset mid-stream with a request in flight.
    do_reset(1'b1);
    tick();
    check_out("rst_mid_lat", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("rst_mid_first", 1'b1, 32'h4, 32'h100);
    repeat (2) tick();

    // PC wrap at the top of the address space.
    branch_taken   = 1'b1;
    branch_address = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    #1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    tick();
    check_out("wrap_out", 1'b1, 32'h0000_0000, 32'h0000_00FC);
    tick();
    check_out("wrap_next", 1'b1, 32'h0000_0004, 32'h0000_0100);

    // Irregular consumer stalls, with a branch in the middle.
    pat = 20'b1011_0010_1110_0101_1001;
    for (int i = 0; i < 20; i++) begin
      out_ready    = pat[i];
      branch_taken = (i == 11);
      branch_address = 32'h1000;
      tick();
    end
    branch_taken = 1'b0;
    out_ready    = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter BIT_NUMBER, default 32, the PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, the prefetch queue entries; legal values are powers of two, 2 or more.
REQ-003 SHALL have parameter PC_STEP, default 4, the PC increment per fetch.
REQ-004 SHALL have parameter RESET_PC, default 0, the first fetch address after reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port branch_taken, input, 1 bit: redirect request.
REQ-008 SHALL have port branch_address, input, BIT_NUMBER bits: redirect target.
REQ-009 SHALL have port imem_req, output, 1 bit: memory read strobe.
REQ-010 SHALL have port imem_addr, output, BIT_NUMBER bits: memory read address.
REQ-011 SHALL have port imem_rdata, input, BIT_NUMBER bits: read data, valid exactly one cycle after imem_req.
REQ-012 SHALL have port out_valid, output, 1 bit: queue head valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the head; it is the inverse of freeze.
REQ-014 SHALL have port pc, output, BIT_NUMBER bits: head fetch address + PC_STEP.
REQ-015 SHALL have port instruction, output, BIT_NUMBER bits: head instruction word.

Function
REQ-016 SHALL hold a fetch_pc register; imem_addr = fetch_pc.
REQ-017 SHALL track inflight, a register set to imem_req at each edge.
REQ-018 SHALL assert imem_req combinationally when branch_taken=0 and (count + inflight) < DEPTH.
REQ-019 SHALL advance fetch_pc by PC_STEP, modulo 2^BIT_NUMBER with wrap, on each edge where imem_req=1.
REQ-020 SHALL push {fetch address of that response, imem_rdata} into the queue when inflight=1 and branch_taken=0.
REQ-021 SHALL drive out_valid = (count != 0).
REQ-022 SHALL make pc and instruction reflect the head entry while out_valid=1, and drive them to 0 while the queue is empty.
REQ-023 SHALL pop the head on an edge where out_valid=1, out_ready=1 and branch_taken=0.
REQ-024 SHALL support a simultaneous push and pop in the same cycle, leaving count unchanged.
REQ-025 SHALL never overflow: the issue rule in REQ-018 guarantees a free slot for every in-flight response; with out_ready=0 the queue fills to exactly DEPTH and imem_req stays low.
REQ-026 SHALL sustain one instruction per cycle when out_ready stays high, after a 2-cycle initial latency from request to out_valid.
REQ-027 SHALL, on an edge with branch_taken=1:
- clear the queue (count=0);
- discard any response arriving that cycle;
- set fetch_pc to branch_address;
- ignore the out_ready handshake.
REQ-028 SHALL make imem_req high with imem_addr = branch_address in the cycle after branch_taken, provided branch_taken is then low.
REQ-029 SHALL let the last branch_address win when branch_taken is high on consecutive cycles, issuing no requests during those cycles.
REQ-030 SHALL use queue read/write pointers that wrap modulo DEPTH, and a count that ranges from 0 to DEPTH.

Reset
REQ-031 SHALL, while rst=1, asynchronously set:
- fetch_pc = RESET_PC;
- count = 0, both pointers = 0, inflight = 0;
- out_valid = 0, pc = 0, instruction = 0.
REQ-032 SHALL drop, via inflight=0, any response to a request issued in the cycle before reset asserted.
REQ-033 SHALL make the first cycle after rst deasserts drive imem_req=1 with imem_addr = RESET_PC.

Verification
REQ-034 Reset, out_ready=1, memory returns addr+0x100 -> out_valid rises 2 cycles after reset release; the stream is pc=0x4/instr=0x100, pc=0x8/instr=0x104, and so on, one per cycle.
REQ-035 out_ready=0 from reset -> after DEPTH=4 responses out_valid=1, count=4, imem_req=0; raising out_ready drains the 4 entries in order and fetching resumes with no gap or duplicate.
REQ-036 branch_taken=1, branch_address=0x200, while the queue holds 3 entries and a request is in flight -> the next cycle has out_valid=0 and imem_addr=0x200; the first output is pc=0x204; no stale entry appears.
REQ-037 branch_taken high for 2 cycles with targets 0x300 then 0x400 -> the next fetch is 0x400 and nothing from 0x300 is delivered.
REQ-038 rst asserted mid-stream with a request in flight -> outputs are 0 immediately; after release the first delivered pc is RESET_PC + 4 and the old response is never delivered.
REQ-039 fetch_pc = 0xFFFFFFFC -> the next fetch address is 0x00000000 and the delivered pc for 0xFFFFFFFC is 0x00000000.
